// File: rtl/muldiv_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide, one iteration per RUN cycle, with divide sign fix-up in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  // Handshake: start is a one-cycle request honoured only when busy is low
  // (IDLE); done/div_zero pulse for one cycle after the operation completes.

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic            op_r;
  logic            sign_a;
  logic            sign_b;
  logic            dz;
  logic [WIDTH:0]  acc;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic            q_m1;

  logic [WIDTH:0]  m_ext;
  logic [WIDTH:0]  booth_sum;
  logic [WIDTH:0]  shifted;
  logic [WIDTH:0]  trial;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign fsm_state = state;

  always_comb begin
    m_ext     = {m_reg[WIDTH-1], m_reg};
    booth_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    // Remainder stays below the divisor magnitude, so its low WIDTH bits suffice.
    shifted = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    trial   = shifted - {1'b0, m_reg};
    a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_mag   = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      op_r     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz       <= 1'b0;
      acc      <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      q_m1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            count  <= CW'(WIDTH);
            acc    <= '0;
            q_m1   <= 1'b0;
            busy   <= 1'b1;
            if (op) begin
              q_reg <= a_mag;
              m_reg <= b_mag;
            end else begin
              q_reg <= b;
              m_reg <= a;
            end
            if (op && (b == '0)) begin
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              dz    <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          count <= count - 1'b1;
          if (op_r) begin
            acc   <= trial[WIDTH] ? shifted : trial;
            q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
          end else begin
            // Arithmetic right shift of {acc, q_reg, q_m1} after the Booth add.
            acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
            q_m1  <= q_reg[0];
          end
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (op_r) begin
            lo <= (sign_a ^ sign_b) ? (~q_reg + 1'b1) : q_reg;
            hi <= sign_a ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
          end else begin
            hi <= acc[WIDTH-1:0];
            lo <= q_reg;
          end
          state <= DONE;
        end
        DONE: begin
          done     <= 1'b1;
          div_zero <= dz;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   fsm_state;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers.
  task automatic model(input logic o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    dz = 1'b0;
    if (!o) begin
      p = sa * sb;
      model_hi = p[63:32];
      model_lo = p[31:0];
    end else if (xb == '0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      model_hi = r[31:0];
      model_lo = q[31:0];
    end
    exp_q.push_back(model_hi);
    exp_q.push_back(model_lo);
  endtask

  // Called at #1 after an edge with the DUT idle.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input bit inject);
    logic dz;
    int n, exp_lat;
    bit seen, busy_ok;
    logic [W-1:0] eh, el;
    model(o, xa, xb, dz);
    exp_lat = dz ? 1 : W + 2;
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    busy_ok = (busy === 1'b1);
    n = 0; seen = 0;
    while (n < 200 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) seen = 1;
      else begin
        if (busy !== 1'b1) busy_ok = 0;
        if (inject) begin
          start = 1'($urandom_range(0, 1));
          op = 1'($urandom); a = $urandom; b = $urandom;
        end
      end
    end
    start = 1'b0;
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_during"}, 64'(busy_ok), 64'(1));
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(dz));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, 64'(done), 64'(0));
    check({tag, "_idle_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    run_op("mul_m2x3", 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    run_op("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op("div_zero", 1'b1, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_inject", 1'b0, 32'h1234_5678, 32'h8765_4321, 1'b1);
    run_op("div_inject", 1'b1, 32'h8000_0000, 32'h0000_0007, 1'b1);
    run_op("mul_minmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("mul_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_bigdiv", 1'b1, 32'd3, 32'h8000_0000, 1'b0);

    // Reset mid-RUN abandons the operation.
    start = 1'b1; op = 1'b0; a = 32'd1000; b = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_run_busy", 64'(busy), 64'(0));
    check("rst_run_done", 64'(done), 64'(0));
    check("rst_run_hi", 64'(hi), 64'(0));
    check("rst_run_lo", 64'(lo), 64'(0));
    model_hi = '0; model_lo = '0;
    begin
      bit any_done = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done === 1'b1) any_done = 1;
      end
      reset = 1'b1;
      repeat (W + 4) begin
        @(posedge clk); #1;
        if (done === 1'b1) any_done = 1;
      end
      check("rst_no_done", 64'(any_done), 64'(0));
      check("rst_hi_hold", 64'(hi), 64'(0));
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 1'b0);

    // Random operations, including some divide-by-zero and extreme operands.
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      ra = $urandom;
      rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
           (sel == 2) ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 3) ra = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), 1'($urandom), ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
